// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the LED bank with a tenure timeout and an idle heartbeat on bit 0.
// Request-to-grant latency is 1 cycle, and leds_o lags grant by 1 cycle; requesters wait only by holding req.
module led_bank_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int HB_DIV         = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        leds_o,
  output logic                    busy,
  output logic                    preempted
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam logic [TW-1:0] TEN_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HB_MAX  = HW'(HB_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   w_grant_nxt;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     w_rr_nxt;
  logic [TW-1:0]     r_tenure;
  logic [TW-1:0]     w_tenure_nxt;
  logic              r_preempted;
  logic              w_pre_nxt;
  logic [HW-1:0]     r_hb_cnt;
  logic              r_hb;
  logic [WIDTH-1:0]  r_leds;

  logic [NREQ-1:0]   w_elig;
  logic              w_found;
  logic [IW-1:0]     w_win_idx;
  logic [NREQ-1:0]   w_win_oh;
  logic [IW-1:0]     w_win_ptr;
  logic              w_owner_req;
  logic [WIDTH-1:0]  w_owner_dat;

  // The current owner is never a candidate; on release its req is already low anyway.
  assign w_elig      = req & ~r_grant;
  assign w_owner_req = |(req & r_grant);
  assign w_win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_win_ptr   = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;

  always_comb begin : p_search
    int v_idx;
    v_idx     = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && w_elig[IW'(v_idx)]) begin
        w_found   = 1'b1;
        w_win_idx = IW'(v_idx);
      end
    end
  end

  always_comb begin
    w_owner_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_owner_dat = w_owner_dat | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_nxt     = r_rr_ptr;
    w_tenure_nxt = r_tenure;
    w_pre_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_OWNED;
          w_grant_nxt  = w_win_oh;
          w_rr_nxt     = w_win_ptr;
          w_tenure_nxt = '0;
        end
      end
      S_OWNED: begin
        if (!w_owner_req) begin
          // Release wins over a coincident timeout, so no pulse here.
          w_tenure_nxt = '0;
          if (w_found) begin
            w_grant_nxt = w_win_oh;
            w_rr_nxt    = w_win_ptr;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end
        end else if (r_tenure == TEN_MAX) begin
          if (w_found) begin
            w_grant_nxt  = w_win_oh;
            w_rr_nxt     = w_win_ptr;
            w_tenure_nxt = '0;
            w_pre_nxt    = 1'b1;
          end
        end else begin
          w_tenure_nxt = r_tenure + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_tenure    <= '0;
      r_preempted <= 1'b0;
      r_hb_cnt    <= '0;
      r_hb        <= 1'b0;
      r_leds      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_tenure    <= w_tenure_nxt;
      r_preempted <= w_pre_nxt;
      if (r_hb_cnt == HB_MAX) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
      // LEDs follow whoever holds the grant this cycle, hence one cycle behind grant.
      r_leds <= (r_state == S_OWNED) ? w_owner_dat : {{(WIDTH-1){1'b0}}, r_hb};
    end
  end

  assign grant     = r_grant;
  assign busy      = |r_grant;
  assign preempted = r_preempted;
  assign leds_o    = r_leds;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NREQ=4, WIDTH=8, TIMEOUT_CYCLES=8, HB_DIV=4.
module tb_led_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [7:0]  leds_o;
  logic        busy;
  logic        preempted;

  int total = 0;
  int bad   = 0;

  led_bank_arbiter #(
    .NREQ(4), .WIDTH(8), .TIMEOUT_CYCLES(8), .HB_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .leds_o(leds_o), .busy(busy), .preempted(preempted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [16:0] hb_pat;

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h11A5_3344;
    hb_pat   = 17'b1111_0000_1111_00000;

    // Reset values
    tick();
    tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_leds", leds_o, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pre", preempted, 1'b0);

    // Idle heartbeat
    do_reset();
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("hb_leds_%0d", k), leds_o, {7'd0, hb_pat[k]});
      chk($sformatf("hb_grant_%0d", k), grant, 4'b0000);
      chk($sformatf("hb_busy_%0d", k), busy, 1'b0);
      tick();
    end

    // Single requester on index 2, other slices ignored
    do_reset();
    req = 4'b0100;
    tick();
    chk("single_grant", grant, 4'b0100);
    chk("single_busy", busy, 1'b1);
    chk("single_leds_lag", leds_o, 8'h00);
    tick();
    chk("single_leds", leds_o, 8'hA5);
    req_data = 32'h115A_3344;
    tick();
    chk("single_leds_upd", leds_o, 8'h5A);
    req = 4'b0000;
    tick();
    chk("single_rel_grant", grant, 4'b0000);
    chk("single_rel_busy", busy, 1'b0);
    chk("single_rel_leds", leds_o, 8'h5A);
    chk("single_rel_pre", preempted, 1'b0);
    tick();
    chk("single_hb_leds", leds_o, 8'h01);
    req_data = 32'h11A5_3344;

    // Round-robin handoff without idle gaps
    do_reset();
    req = 4'b1011;
    tick();
    chk("rr_g0", grant, 4'b0001);
    tick();
    chk("rr_g0_hold", grant, 4'b0001);
    req = 4'b1010;
    tick();
    chk("rr_g1", grant, 4'b0010);
    chk("rr_g1_busy", busy, 1'b1);
    chk("rr_g1_pre", preempted, 1'b0);
    tick();
    chk("rr_g1_hold", grant, 4'b0010);
    req = 4'b1000;
    tick();
    chk("rr_g3", grant, 4'b1000);
    chk("rr_g3_pre", preempted, 1'b0);
    req = 4'b0000;
    tick();
    chk("rr_idle", grant, 4'b0000);

    // Timeout preemption
    do_reset();
    req = 4'b0001;
    tick();
    chk("to_g0", grant, 4'b0001);
    tick();
    tick();
    tick();
    req = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("to_hold_%0d", k), grant, 4'b0001);
      chk($sformatf("to_nopre_%0d", k), preempted, 1'b0);
      tick();
    end
    chk("to_g2", grant, 4'b0100);
    chk("to_pulse", preempted, 1'b1);
    tick();
    chk("to_g2_hold", grant, 4'b0100);
    chk("to_pulse_end", preempted, 1'b0);
    tick();
    chk("to_g2_hold2", grant, 4'b0100);
    req = 4'b0001;
    tick();
    chk("to_back_g0", grant, 4'b0001);
    chk("to_back_pre", preempted, 1'b0);

    // Saturation with a lone requester
    do_reset();
    req = 4'b0010;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat_grant_%0d", k), grant, 4'b0010);
      chk($sformatf("sat_pre_%0d", k), preempted, 1'b0);
      tick();
    end
    req = 4'b1010;
    tick();
    chk("sat_g3", grant, 4'b1000);
    chk("sat_pulse", preempted, 1'b1);
    tick();
    chk("sat_pulse_end", preempted, 1'b0);
    chk("sat_g3_hold", grant, 4'b1000);

    // Reset mid-tenure, then arbitration restarts from index 0
    do_reset();
    req = 4'b0010;
    tick();
    chk("mid_g1", grant, 4'b0010);
    tick();
    tick();
    chk("mid_leds", leds_o, 8'h33);
    reset = 1'b1;
    req   = 4'b1010;
    tick();
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_leds", leds_o, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pre", preempted, 1'b0);
    tick();
    chk("mid_rst_grant2", grant, 4'b0000);
    reset = 1'b0;
    tick();
    chk("mid_restart_g1", grant, 4'b0010);
    chk("mid_restart_pre", preempted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the 8-bit LED output bank between NREQ independent requesters, e.g. PS GPIO, an RTOS task-state monitor and a fault indicator.
- Sits between the requesters and the leds_8bits_tri_o pins.
- Grants ownership round-robin, with a tenure timeout so one requester cannot hold the bank forever.
- When the bank is unowned, it drives a heartbeat on bit 0.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: LED bank width.
- TIMEOUT_CYCLES, 50000000: maximum tenure while another requester is waiting (>=2).
- HB_DIV, 25000000: heartbeat half-period in cycles (>=1).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- req, input, NREQ: per-requester ownership request, level-sensitive.
- req_data, input, NREQ*WIDTH: per-requester LED pattern; requester i occupies bits [i*WIDTH +: WIDTH].
- grant, output, NREQ: one-hot current owner, or all-zero when idle.
- leds_o, output, WIDTH: registered LED drive.
- busy, output, 1: high while any grant is asserted.
- preempted, output, 1: one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. All state is registered.
- Reset values:
  - grant=0, busy=0, preempted=0, leds_o=0.
  - Round-robin pointer rr_ptr=0.
  - Tenure counter=0, heartbeat counter=0, hb=0.
- States: IDLE (grant==0) and OWNED (grant one-hot). busy = |grant.
- Arbitration search: starts at index rr_ptr and wraps modulo NREQ, excluding the current owner when preempting. The first index with req high wins.
- IDLE:
  - If any req is high at edge N, grant is asserted at edge N (visible cycle N+1). This is a 1-cycle request-to-grant latency.
  - rr_ptr := (winner+1) mod NREQ.
  - Tenure counter := 0.
- OWNED, owner's req still high and tenure < TIMEOUT_CYCLES-1: tenure increments; grant is held.
- OWNED, owner's req drops:
  - At that edge, grant moves directly to the next winner (no idle gap), or to 0 if no other req is high.
  - Tenure := 0. rr_ptr advances as in IDLE. preempted stays 0.
- OWNED, timeout:
  - Condition: tenure == TIMEOUT_CYCLES-1 and at least one other req is high.
  - At that edge, grant moves to the next winner, preempted=1 for exactly one cycle, tenure := 0.
  - The old owner may win again only after the search passes it.
- OWNED, tenure reaches TIMEOUT_CYCLES-1 with no other requester: tenure saturates and the owner keeps the grant, with no pulse. If another requester appears later, preemption occurs at the next edge.
- Simultaneous owner-drop and timeout: treated as a normal release, preempted=0.
- Requests arriving at the same edge: the rr_ptr order decides; there are no fixed priorities.
- leds_o is registered from the grant being driven in the current cycle.
  - OWNED: leds_o at edge N+1 = req_data slice of the owner during cycle N, i.e. 1 cycle behind grant.
  - IDLE: leds_o = {WIDTH-1 zeros, hb}.
- Heartbeat: the counter runs continuously, including while OWNED. hb toggles when the counter reaches HB_DIV-1, then the counter wraps to 0.
- req_data of non-owners is ignored. Changes to the owner's data appear on leds_o 1 cycle later.
- Reset asserted mid-tenure: all outputs return to reset values at that edge; no grant and no pulse until reset deasserts.

Test Plan (bench parameters NREQ=4, WIDTH=8, TIMEOUT_CYCLES=8, HB_DIV=4):
- Idle heartbeat: reset then no req.
  - leds_o = 0x00 for 4 cycles, then 0x01 for 4 cycles, then repeats.
  - grant=0, busy=0 throughout.
- Single requester: req=4'b0100 with its data slice 0xA5.
  - grant=4'b0100 at the next cycle, leds_o=0xA5 one cycle later.
  - Dropping req gives grant=0 next cycle and leds_o returns to the heartbeat pattern.
- Round-robin handoff: req=4'b1011 together from reset.
  - grant goes 0001, then 0010 after req[0] drops, then 1000 after req[1] drops.
  - No idle cycle between grants.
- Timeout preemption: req[0] held, req[2] raised at tenure 3.
  - After 8 cycles of tenure, grant becomes 0100 with preempted=1 for one cycle.
  - The requester at index 0 is re-granted only after req[2] releases.
- Saturation: req[1] alone for 20 cycles.
  - Grant held, preempted never pulses.
  - Raising req[3] at cycle 20 moves grant to 1000 at the next edge with preempted=1.
- Reset mid-tenure: assert reset while grant=0010.
  - Next cycle: grant=0, leds_o=0x00, busy=0, preempted=0.
  - After release, the first arbitration starts from index 0.
